// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// then a RISC-V byte/half/word access on a local word array.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [33:0] LIMIT = 34'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          f3_ok, align_ok, range_ok, legal;
    logic          acc_we;
    logic [2:0]    acc_f3;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic [AW-1:0] idx;
    logic [31:0]   word, load_data, store_data;
    logic [3:0]    byte_en;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic          do_access;

    assign req_ready = (state == StIdle);

    always_comb begin
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_we;
            default:                f3_ok = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b01:   align_ok = !req_addr[0];
            2'b10:   align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        // Widened compare so no address ever wraps into range.
        range_ok = ({2'b00, req_addr} < LIMIT);
        legal    = f3_ok && align_ok && range_ok;
    end

    // Zero-wait accesses use the live request; otherwise the captured one.
    always_comb begin
        if (state == StIdle) begin
            acc_we    = req_we;
            acc_f3    = req_funct3;
            acc_addr  = req_addr[AW+1:0];
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_f3    = funct3_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    assign idx  = acc_addr[AW+1:2];
    assign word = mem[idx];

    always_comb begin
        sel_byte   = word[{acc_addr[1:0], 3'b000} +: 8];
        sel_half   = acc_addr[1] ? word[31:16] : word[15:0];
        load_data  = word;
        store_data = acc_wdata;
        byte_en    = 4'b1111;
        case (acc_f3[1:0])
            2'b00: begin
                load_data  = {{24{sel_byte[7] & ~acc_f3[2]}}, sel_byte};
                store_data = {4{acc_wdata[7:0]}};
                byte_en    = 4'b0001 << acc_addr[1:0];
            end
            2'b01: begin
                load_data  = {{16{sel_half[15] & ~acc_f3[2]}}, sel_half};
                store_data = {2{acc_wdata[15:0]}};
                byte_en    = acc_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign do_access = rst &&
        (((state == StIdle) && req_valid && legal && (WAIT_CYCLES == 0)) ||
         ((state == StWait) && (cnt == '0)));

    always_ff @(posedge clk) begin
        if (do_access && acc_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[idx][8*i +: 8] <= store_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= StIdle;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr[AW+1:0];
                        wdata_q  <= req_wdata;
                        if (!legal) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (WAIT_CYCLES == 0) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= acc_we ? '0 : load_data;
                        end else begin
                            state <= StWait;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (cnt == '0) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= acc_we ? '0 : load_data;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
